svc_rv_fwd_ex_cap: RTL and testbench
====================================

Name: svc_rv_fwd_ex_cap

Overview:
EX-stage operand forwarding unit for the svc_rv pipeline, generalised to NRS source operands and two forwarding sources: MEM, plus WB when WB_FWD=1. It detects hazards that forwarding cannot resolve and raises a stall request for them. It owns the multi-cycle (DIV/REM) operand capture registers and the IDLE/BUSY state machine that holds captured operands while the pipeline drains.

Parameters:
XLEN, 32, data width
NRS, 2, number of source operands (2 or 3)
MEM_TYPE, 0, 0=SRAM (load data valid in MEM, forwardable); 1=BRAM (load data not valid until WB)
WB_FWD, 1, 1=forward from WB stage; 0=no WB forwarding (regfile write-through assumed)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rs_ex  in  NRS*5  source register indices; operand i at [5i+:5]; index 0 = operand unused
rs_data_ex  in  NRS*XLEN  regfile read data per operand
rd_mem  in  5  MEM-stage destination register
reg_write_mem  in  1  MEM-stage writes rd
res_src_mem  in  3  MEM result source: 0 ALU, 1 load, 2 PC+4, 3 reserved (treated as ALU), 4 CSR, 5-7 treated as CSR
result_mem  in  XLEN  MEM-stage ALU/PC+4 result
load_data_mem  in  XLEN  MEM-stage load data (used only when MEM_TYPE=0)
rd_wb  in  5  WB-stage destination register
reg_write_wb  in  1  WB-stage writes rd
result_wb  in  XLEN  WB-stage final result
mc_start  in  1  EX holds first cycle of a multi-cycle op
mc_done  in  1  multi-cycle op completes this cycle
fwd_data_ex  out  NRS*XLEN  forwarded operand values
fwd_stall  out  1  unresolvable hazard; EX must stall
mc_active  out  1  FSM in BUSY

Behaviour:
- Match per operand i: mem_hit = reg_write_mem & rd_mem!=0 & rd_mem==rs_i & rs_i!=0. wb_hit is defined the same way with the WB signals and is gated by WB_FWD.
- Priority per operand: captured value (BUSY) > MEM > WB > rs_data_ex.
- MEM value selection:
  - res_src 0/2/3 → result_mem.
  - res_src 1 → load_data_mem, only if MEM_TYPE=0.
  - res_src 1 with MEM_TYPE=1, or res_src ≥4 → no forward. Operand falls through to WB/regfile and fwd_stall=1.
- fwd_stall is the OR over operands of these unresolvable MEM hits. It is combinational and forced to 0 in BUSY.
- Operand with rs_i=0 always passes rs_data_ex unchanged and never stalls.
- FSM, reset → IDLE:
  - IDLE → BUSY on mc_start & !fwd_stall & !mc_done. On that edge, cap[i] <= current combinational fwd value for every operand.
  - IDLE with mc_start & mc_done (single-cycle completion): stay IDLE, no capture.
  - IDLE with mc_start & fwd_stall: stay IDLE, no capture; the start retries next cycle.
  - BUSY: fwd_data_ex = cap[i]. MEM/WB hits are ignored.
  - BUSY → IDLE on mc_done & !mc_start.
  - BUSY with mc_done & mc_start (back-to-back op): stay BUSY. Recapture from the uncaptured forward path, i.e. evaluated as if IDLE.
- mc_active = (state==BUSY), registered.
- Reset values: state IDLE, cap[*]=0, mc_active=0. Reset mid-BUSY returns to IDLE on the next edge; outputs revert to the combinational path.
- Outputs are combinational except mc_active, which is registered. Forwarding latency is 0 cycles. Capture takes effect 1 cycle after mc_start.

Optional Feature:
SVC_RV_FWD_STATS_EN
- Defined: adds outputs stat_fwd_cnt[31:0] and stat_stall_cnt[31:0]. These are saturating counters, reset to 0.
  - stat_fwd_cnt increments by 1 for each cycle in IDLE where any operand is MEM- or WB-forwarded.
  - stat_stall_cnt increments by 1 for each cycle fwd_stall=1.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters do not exist. Core behaviour is identical in both builds.

Test Plan:
1. NRS=2, rs=(10,2), rs_data=(AAAAAAAA,BBBBBBBB), MEM rd=10 res_src=0 result_mem=FEEDBEEF, WB rd=10 result_wb=11111111 → fwd=(FEEDBEEF,BBBBBBBB), fwd_stall=0 (MEM beats WB).
2. rs=(2,10), no MEM hit, WB rd=10 reg_write_wb=1 result_wb=CAFEBABE → fwd=(AAAAAAAA,CAFEBABE). With WB_FWD=0 → (AAAAAAAA,BBBBBBBB).
3. MEM_TYPE=1, rs1=10, MEM rd=10 res_src=1 load_data_mem=12340000 → fwd_rs1=AAAAAAAA, fwd_stall=1. Same with MEM_TYPE=0 → fwd_rs1=12340000, fwd_stall=0. res_src=4 → fwd_stall=1 for both MEM_TYPE values.
4. mc_start=1, rs=(10,10), MEM result_mem=84080000. Next cycle: mc_start=0, MEM rd=10 result_mem=DEADBEEF → fwd=(84080000,84080000), mc_active=1. Assert mc_done → IDLE next cycle and fwd=DEADBEEF.
5. mc_start with fwd_stall=1 (MEM CSR hit) → stays IDLE, mc_active=0. Next cycle, stall cleared → capture occurs. Then mc_done & mc_start together in BUSY → stays BUSY with the new captured values.
6. rst=1 during BUSY → next edge mc_active=0, cap=0, fwd follows the combinational path. With SVC_RV_FWD_STATS_EN: 3 forwarding cycles → stat_fwd_cnt=3; counters preloaded at FFFFFFFF stay at FFFFFFFF.

Source files
------------

// File: rtl/svc_rv_fwd_ex_cap_if.sv
// svc_rv EX forwarding bundle: pipeline-side inputs and forwarded results.
// The master modport drives operands and pipeline state; the slave is the unit.
interface svc_rv_fwd_ex_cap_if #(
  parameter int XLEN = 32,
  parameter int NRS  = 2
);
  logic [NRS*5-1:0]    rs_ex;
  logic [NRS*XLEN-1:0] rs_data_ex;
  logic [4:0]          rd_mem;
  logic                reg_write_mem;
  logic [2:0]          res_src_mem;
  logic [XLEN-1:0]     result_mem;
  logic [XLEN-1:0]     load_data_mem;
  logic [4:0]          rd_wb;
  logic                reg_write_wb;
  logic [XLEN-1:0]     result_wb;
  logic                mc_start;
  logic                mc_done;
  logic [NRS*XLEN-1:0] fwd_data_ex;
  logic                fwd_stall;
  logic                mc_active;

  modport master (
    output rs_ex, rs_data_ex,
    output rd_mem, reg_write_mem, res_src_mem,
    output result_mem, load_data_mem,
    output rd_wb, reg_write_wb, result_wb,
    output mc_start, mc_done,
    input  fwd_data_ex, fwd_stall, mc_active
  );

  modport slave (
    input  rs_ex, rs_data_ex,
    input  rd_mem, reg_write_mem, res_src_mem,
    input  result_mem, load_data_mem,
    input  rd_wb, reg_write_wb, result_wb,
    input  mc_start, mc_done,
    output fwd_data_ex, fwd_stall, mc_active
  );
endinterface

// File: rtl/svc_rv_fwd_ex_cap.sv
// svc_rv EX operand forwarding with multi-cycle operand capture.
// Optional SVC_RV_FWD_STATS_EN adds saturating forward/stall counters.
module svc_rv_fwd_ex_cap #(
  parameter int XLEN     = 32,
  parameter int NRS      = 2,
  parameter int MEM_TYPE = 0,
  parameter int WB_FWD   = 1
) (
  input logic clk,
  input logic rst,
  svc_rv_fwd_ex_cap_if.slave bus
`ifdef SVC_RV_FWD_STATS_EN
  ,
  output logic [31:0] stat_fwd_cnt,
  output logic [31:0] stat_stall_cnt
`endif
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   cap_en;

  logic [XLEN-1:0] cap_q    [NRS];
  logic [XLEN-1:0] fwd_comb [NRS];
  logic [NRS-1:0]  stall_op;
  logic [NRS-1:0]  fwd_op;
  logic            raw_stall;
  logic            mem_ok;
  logic [XLEN-1:0] mem_val;

  // Which MEM results exist in time to forward
  always_comb begin
    mem_ok  = 1'b0;
    mem_val = bus.result_mem;
    unique case (1'b1)
      bus.res_src_mem == 3'd0,
      bus.res_src_mem == 3'd2,
      bus.res_src_mem == 3'd3: mem_ok = 1'b1;
      bus.res_src_mem == 3'd1: begin
        mem_ok  = (MEM_TYPE == 0);
        mem_val = bus.load_data_mem;
      end
      default: mem_ok = 1'b0;
    endcase
  end

  always_comb begin
    logic [4:0] rs;
    logic       mem_hit;
    logic       wb_hit;
    for (int i = 0; i < NRS; i++) begin
      rs          = bus.rs_ex[5*i+:5];
      mem_hit     = bus.reg_write_mem &&
                    bus.rd_mem != 5'd0 &&
                    bus.rd_mem == rs && rs != 5'd0;
      wb_hit      = (WB_FWD != 0) && bus.reg_write_wb &&
                    bus.rd_wb != 5'd0 &&
                    bus.rd_wb == rs && rs != 5'd0;
      fwd_comb[i] = bus.rs_data_ex[XLEN*i+:XLEN];
      stall_op[i] = 1'b0;
      fwd_op[i]   = 1'b0;
      if (mem_hit && mem_ok) begin
        fwd_comb[i] = mem_val;
        fwd_op[i]   = 1'b1;
      end else begin
        stall_op[i] = mem_hit;
        if (wb_hit) begin
          fwd_comb[i] = bus.result_wb;
          fwd_op[i]   = 1'b1;
        end
      end
    end
  end

  assign raw_stall = |stall_op;

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mc_start && !raw_stall && !bus.mc_done) begin
          state_d = BUSY;
          cap_en  = 1'b1;
        end
      end
      BUSY: begin
        if (bus.mc_done && !bus.mc_start) begin
          state_d = IDLE;
        end else if (bus.mc_done && bus.mc_start) begin
          cap_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NRS; i++) cap_q[i] <= '0;
    end else if (cap_en) begin
      for (int i = 0; i < NRS; i++) cap_q[i] <= fwd_comb[i];
    end
  end

  always_comb begin
    bus.fwd_data_ex = '0;
    for (int i = 0; i < NRS; i++) begin
      bus.fwd_data_ex[XLEN*i+:XLEN] =
        (state_q == BUSY) ? cap_q[i] : fwd_comb[i];
    end
  end

  assign bus.fwd_stall = raw_stall && (state_q == IDLE);
  assign bus.mc_active = (state_q == BUSY);

`ifdef SVC_RV_FWD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fwd_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (state_q == IDLE && |fwd_op && stat_fwd_cnt != '1)
        stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
      if (bus.fwd_stall && stat_stall_cnt != '1)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_svc_rv_fwd_ex_cap.sv
// Directed bench: instance a (SRAM, WB forwarding) and instance b
// (BRAM, no WB forwarding) share one stimulus stream.
module tb_svc_rv_fwd_ex_cap;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rs_ex;
  logic [63:0] rs_data_ex;
  logic [4:0]  rd_mem;
  logic        reg_write_mem;
  logic [2:0]  res_src_mem;
  logic [31:0] result_mem;
  logic [31:0] load_data_mem;
  logic [4:0]  rd_wb;
  logic        reg_write_wb;
  logic [31:0] result_wb;
  logic        mc_start;
  logic        mc_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  svc_rv_fwd_ex_cap_if #(.XLEN(32), .NRS(2)) ia ();
  svc_rv_fwd_ex_cap_if #(.XLEN(32), .NRS(2)) ib ();

  assign ia.rs_ex         = rs_ex;
  assign ia.rs_data_ex    = rs_data_ex;
  assign ia.rd_mem        = rd_mem;
  assign ia.reg_write_mem = reg_write_mem;
  assign ia.res_src_mem   = res_src_mem;
  assign ia.result_mem    = result_mem;
  assign ia.load_data_mem = load_data_mem;
  assign ia.rd_wb         = rd_wb;
  assign ia.reg_write_wb  = reg_write_wb;
  assign ia.result_wb     = result_wb;
  assign ia.mc_start      = mc_start;
  assign ia.mc_done       = mc_done;

  assign ib.rs_ex         = rs_ex;
  assign ib.rs_data_ex    = rs_data_ex;
  assign ib.rd_mem        = rd_mem;
  assign ib.reg_write_mem = reg_write_mem;
  assign ib.res_src_mem   = res_src_mem;
  assign ib.result_mem    = result_mem;
  assign ib.load_data_mem = load_data_mem;
  assign ib.rd_wb         = rd_wb;
  assign ib.reg_write_wb  = reg_write_wb;
  assign ib.result_wb     = result_wb;
  assign ib.mc_start      = mc_start;
  assign ib.mc_done       = mc_done;

`ifdef SVC_RV_FWD_STATS_EN
  logic [31:0] fcnt_a, scnt_a, fcnt_b, scnt_b;
`endif

  svc_rv_fwd_ex_cap #(
    .XLEN(32), .NRS(2), .MEM_TYPE(0), .WB_FWD(1)
  ) u_a (
    .clk(clk),
    .rst(rst),
    .bus(ia.slave)
`ifdef SVC_RV_FWD_STATS_EN
    ,
    .stat_fwd_cnt(fcnt_a),
    .stat_stall_cnt(scnt_a)
`endif
  );

  svc_rv_fwd_ex_cap #(
    .XLEN(32), .NRS(2), .MEM_TYPE(1), .WB_FWD(0)
  ) u_b (
    .clk(clk),
    .rst(rst),
    .bus(ib.slave)
`ifdef SVC_RV_FWD_STATS_EN
    ,
    .stat_fwd_cnt(fcnt_b),
    .stat_stall_cnt(scnt_b)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    rs_ex         = {5'd2, 5'd10};
    rs_data_ex    = {32'hBBBBBBBB, 32'hAAAAAAAA};
    rd_mem        = 5'd0;
    reg_write_mem = 1'b0;
    res_src_mem   = 3'd0;
    result_mem    = '0;
    load_data_mem = '0;
    rd_wb         = 5'd0;
    reg_write_wb  = 1'b0;
    result_wb     = '0;
    mc_start      = 1'b0;
    mc_done       = 1'b0;
    tick();
    tick();
    chk("rst_active_a", {63'd0, ia.mc_active}, 64'd0);
    chk("rst_fwd_a", ia.fwd_data_ex, {32'hBBBBBBBB, 32'hAAAAAAAA});
    chk("rst_stall_a", {63'd0, ia.fwd_stall}, 64'd0);
    rst = 1'b0;
    tick();

    // MEM beats WB
    rd_mem = 5'd10; reg_write_mem = 1'b1; res_src_mem = 3'd0;
    result_mem = 32'hFEEDBEEF;
    rd_wb = 5'd10; reg_write_wb = 1'b1; result_wb = 32'h11111111;
    #1;
    chk("mem_wb_a", ia.fwd_data_ex, {32'hBBBBBBBB, 32'hFEEDBEEF});
    chk("mem_wb_stall_a", {63'd0, ia.fwd_stall}, 64'd0);
    chk("mem_wb_b", ib.fwd_data_ex, {32'hBBBBBBBB, 32'hFEEDBEEF});

    // WB only, gated by WB_FWD
    rs_ex = {5'd10, 5'd2}; reg_write_mem = 1'b0;
    result_wb = 32'hCAFEBABE;
    #1;
    chk("wb_a", ia.fwd_data_ex, {32'hCAFEBABE, 32'hAAAAAAAA});
    chk("wb_off_b", ib.fwd_data_ex, {32'hBBBBBBBB, 32'hAAAAAAAA});

    // load forwarding depends on MEM_TYPE
    rs_ex = {5'd2, 5'd10}; reg_write_wb = 1'b0;
    reg_write_mem = 1'b1; res_src_mem = 3'd1;
    load_data_mem = 32'h12340000;
    #1;
    chk("ld_a", ia.fwd_data_ex, {32'hBBBBBBBB, 32'h12340000});
    chk("ld_stall_a", {63'd0, ia.fwd_stall}, 64'd0);
    chk("ld_b", ib.fwd_data_ex, {32'hBBBBBBBB, 32'hAAAAAAAA});
    chk("ld_stall_b", {63'd0, ib.fwd_stall}, 64'd1);

    res_src_mem = 3'd4;
    #1;
    chk("csr_stall_a", {63'd0, ia.fwd_stall}, 64'd1);
    chk("csr_stall_b", {63'd0, ib.fwd_stall}, 64'd1);
    chk("csr_fwd_a", ia.fwd_data_ex, {32'hBBBBBBBB, 32'hAAAAAAAA});

    res_src_mem = 3'd7;
    #1;
    chk("src7_stall_a", {63'd0, ia.fwd_stall}, 64'd1);

    res_src_mem = 3'd2; result_mem = 32'h00000104;
    #1;
    chk("pc4_a", ia.fwd_data_ex, {32'hBBBBBBBB, 32'h00000104});

    res_src_mem = 3'd3; result_mem = 32'h00000333;
    #1;
    chk("src3_b", ib.fwd_data_ex, {32'hBBBBBBBB, 32'h00000333});

    // x0 never forwards or stalls
    rs_ex = 10'd0; rd_mem = 5'd0; res_src_mem = 3'd4;
    #1;
    chk("x0_fwd_a", ia.fwd_data_ex, {32'hBBBBBBBB, 32'hAAAAAAAA});
    chk("x0_stall_a", {63'd0, ia.fwd_stall}, 64'd0);

    // capture into BUSY
    rs_ex = {5'd10, 5'd10}; rd_mem = 5'd10; res_src_mem = 3'd0;
    result_mem = 32'h84080000; mc_start = 1'b1;
    #1;
    chk("pre_cap_active_a", {63'd0, ia.mc_active}, 64'd0);
    tick();
    mc_start = 1'b0; result_mem = 32'hDEADBEEF;
    #1;
    chk("cap_fwd_a", ia.fwd_data_ex, {32'h84080000, 32'h84080000});
    chk("cap_active_a", {63'd0, ia.mc_active}, 64'd1);
    chk("cap_fwd_b", ib.fwd_data_ex, {32'h84080000, 32'h84080000});
    res_src_mem = 3'd4;
    #1;
    chk("busy_nostall_a", {63'd0, ia.fwd_stall}, 64'd0);
    res_src_mem = 3'd0; mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    #1;
    chk("done_active_a", {63'd0, ia.mc_active}, 64'd0);
    chk("done_fwd_a", ia.fwd_data_ex, {32'hDEADBEEF, 32'hDEADBEEF});

    // start blocked by stall, then retried
    res_src_mem = 3'd4; mc_start = 1'b1;
    #1;
    chk("blk_stall_a", {63'd0, ia.fwd_stall}, 64'd1);
    tick();
    chk("blk_active_a", {63'd0, ia.mc_active}, 64'd0);
    res_src_mem = 3'd0; result_mem = 32'h55550000;
    tick();
    result_mem = 32'h66660000; mc_start = 1'b0;
    #1;
    chk("retry_active_a", {63'd0, ia.mc_active}, 64'd1);
    chk("retry_fwd_a", ia.fwd_data_ex, {32'h55550000, 32'h55550000});

    // back-to-back op recaptures
    mc_start = 1'b1; mc_done = 1'b1; result_mem = 32'h77770000;
    tick();
    mc_start = 1'b0; mc_done = 1'b0; result_mem = 32'h88880000;
    #1;
    chk("b2b_active_a", {63'd0, ia.mc_active}, 64'd1);
    chk("b2b_fwd_a", ia.fwd_data_ex, {32'h77770000, 32'h77770000});

    // single-cycle completion stays IDLE: leave BUSY first
    mc_done = 1'b1;
    tick();
    mc_start = 1'b1;
    tick();
    mc_start = 1'b0; mc_done = 1'b0;
    #1;
    chk("single_active_a", {63'd0, ia.mc_active}, 64'd0);

    // reset during BUSY
    mc_start = 1'b1; result_mem = 32'h99990000;
    tick();
    mc_start = 1'b0;
    #1;
    chk("busy2_active_a", {63'd0, ia.mc_active}, 64'd1);
    result_mem = 32'h88880000; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstb_active_a", {63'd0, ia.mc_active}, 64'd0);
    chk("rstb_fwd_a", ia.fwd_data_ex, {32'h88880000, 32'h88880000});

`ifdef SVC_RV_FWD_STATS_EN
    reg_write_mem = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stat_rst_a", {32'd0, fcnt_a}, 64'd0);
    reg_write_mem = 1'b1; res_src_mem = 3'd0;
    tick();
    tick();
    tick();
    reg_write_mem = 1'b0;
    tick();
    chk("stat_fwd_a", {32'd0, fcnt_a}, 64'd3);
    chk("stat_stall_a", {32'd0, scnt_a}, 64'd0);
    chk("stat_fwd_b", {32'd0, fcnt_b}, 64'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
